posit_extract_pipe: RTL and testbench

- Pipelined, parametrised posit decoder: splits a posit into sign, zero/NaR flags, combined scale (k·2^ES + e), left-aligned fraction and absolute magnitude.
- Generalises the combinational ES=3 extractor to any NBITS/ES, with two register stages, valid/ready flow control and a sideband tag. The tag carries PairHMM cell/lane IDs through the decode.
- Sits between the posit input stream and the posit add/mul datapaths.

---
 rtl/posit_extract_pipe_if.sv | 37 +++
 rtl/posit_extract_pipe.sv | 172 +++++++++++++++++
 tb/tb_posit_extract_pipe.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/posit_extract_pipe_if.sv
// Stream bundle for the posit decoder: raw posit + tag in, decoded fields + tag out.
// slave is the decoder's view, master is the producer/consumer environment's view.
interface posit_extract_pipe_if #(
  parameter int NBITS = 32,
  parameter int ES    = 3,
  parameter int TAG_W = 8
);
  localparam int SBITS = $clog2(NBITS) + ES + 1;
  localparam int FBITS = NBITS - ES - 3;

  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] in_data;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic             out_zero;
  logic             out_inf;
  logic [SBITS-1:0] out_scale;
  logic [FBITS-1:0] out_fraction;
  logic [NBITS-2:0] out_abs;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_sign, out_zero, out_inf,
           out_scale, out_fraction, out_abs, out_tag
  );

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_sign, out_zero, out_inf,
           out_scale, out_fraction, out_abs, out_tag
  );
endinterface

// File: rtl/posit_extract_pipe.sv
// Two-stage posit decoder: stage 1 takes |x| and flags, stage 2 decodes regime/exponent/fraction.
// Latency 2 cycles, 1/cycle throughput; in_ready drops only when both stages are full and out_ready is low.
module posit_extract_pipe #(
  parameter int NBITS = 32,
  parameter int ES    = 3,
  parameter int TAG_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  posit_extract_pipe_if.slave io
);
  localparam int SBITS = $clog2(NBITS) + ES + 1;
  localparam int FBITS = NBITS - ES - 3;
  localparam int MW    = $clog2(NBITS) + 1;
  localparam int IW    = $clog2(NBITS);
  localparam int EW    = (ES > 0) ? ES : 1;

  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n_int;

  logic adv1, adv2;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_sign_q,  s1_sign_d;
  logic             s1_zero_q,  s1_zero_d;
  logic             s1_inf_q,   s1_inf_d;
  logic [NBITS-2:0] s1_u_q,     s1_u_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

  logic             s2_valid_q, s2_valid_d;
  logic             s2_sign_q,  s2_sign_d;
  logic             s2_zero_q,  s2_zero_d;
  logic             s2_inf_q,   s2_inf_d;
  logic [SBITS-1:0] s2_scale_q, s2_scale_d;
  logic [FBITS-1:0] s2_frac_q,  s2_frac_d;
  logic [NBITS-2:0] s2_abs_q,   s2_abs_d;
  logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;

  logic                    reg_bit;
  logic                    run;
  logic [MW-1:0]           m;
  logic [MW-1:0]           sh;
  logic signed [SBITS-1:0] m_s;
  logic signed [SBITS-1:0] k;
  logic signed [SBITS-1:0] dec_scale;
  logic [EW-1:0]           dec_e;
  logic [FBITS-1:0]        dec_frac;
  int                      p;

  // Reset asserts asynchronously but releases on a clock edge.
  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= rst_sync_d;
  end

  assign rst_n_int = rst_sync_q[1];

  always_comb begin
    adv2 = !s2_valid_q || io.out_ready;
    adv1 = !s1_valid_q || adv2;
  end

  always_comb begin
    s1_valid_d = adv1 ? io.in_valid : s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_zero_d  = s1_zero_q;
    s1_inf_d   = s1_inf_q;
    s1_u_d     = s1_u_q;
    s1_tag_d   = s1_tag_q;
    if (adv1 && io.in_valid) begin
      s1_sign_d = io.in_data[NBITS-1];
      s1_zero_d = (io.in_data == '0);
      s1_inf_d  = (io.in_data == {1'b1, {(NBITS-1){1'b0}}});
      // Low bits of the negation equal the negation of the low bits.
      s1_u_d    = io.in_data[NBITS-1] ? (~io.in_data[NBITS-2:0] + (NBITS-1)'(1))
                                      : io.in_data[NBITS-2:0];
      s1_tag_d  = io.in_tag;
    end
  end

  always_comb begin
    reg_bit  = s1_u_q[NBITS-2];
    m        = '0;
    run      = 1'b1;
    p        = 0;
    dec_e    = '0;
    dec_frac = '0;
    for (int i = NBITS - 2; i >= 0; i--) begin
      if (run && (s1_u_q[i] == reg_bit)) m = m + MW'(1);
      else                               run = 1'b0;
    end
    sh  = m + MW'(1);
    m_s = SBITS'(m);
    k   = reg_bit ? (m_s - SBITS'(1)) : -m_s;
    // Bit positions that fall below the LSB simply stay zero.
    for (int j = 0; j < ES; j++) begin
      p = NBITS - 2 - int'(sh) - j;
      if (p >= 0) dec_e[ES-1-j] = s1_u_q[p[IW-1:0]];
    end
    for (int j = 0; j < FBITS; j++) begin
      p = NBITS - 2 - int'(sh) - ES - j;
      if (p >= 0) dec_frac[FBITS-1-j] = s1_u_q[p[IW-1:0]];
    end
    dec_scale = (k <<< ES) + SBITS'(dec_e);
  end

  always_comb begin
    s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_zero_d  = s2_zero_q;
    s2_inf_d   = s2_inf_q;
    s2_scale_d = s2_scale_q;
    s2_frac_d  = s2_frac_q;
    s2_abs_d   = s2_abs_q;
    s2_tag_d   = s2_tag_q;
    if (adv2 && s1_valid_q) begin
      s2_sign_d  = s1_sign_q;
      s2_zero_d  = s1_zero_q;
      s2_inf_d   = s1_inf_q;
      s2_scale_d = (s1_zero_q || s1_inf_q) ? '0 : dec_scale;
      s2_frac_d  = (s1_zero_q || s1_inf_q) ? '0 : dec_frac;
      s2_abs_d   = (s1_zero_q || s1_inf_q) ? '0 : s1_u_q;
      s2_tag_d   = s1_tag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_inf_q   <= 1'b0;
      s1_u_q     <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_inf_q   <= 1'b0;
      s2_scale_q <= '0;
      s2_frac_q  <= '0;
      s2_abs_q   <= '0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_zero_q  <= s1_zero_d;
      s1_inf_q   <= s1_inf_d;
      s1_u_q     <= s1_u_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_sign_q  <= s2_sign_d;
      s2_zero_q  <= s2_zero_d;
      s2_inf_q   <= s2_inf_d;
      s2_scale_q <= s2_scale_d;
      s2_frac_q  <= s2_frac_d;
      s2_abs_q   <= s2_abs_d;
      s2_tag_q   <= s2_tag_d;
    end
  end

  assign io.in_ready     = adv1;
  assign io.out_valid    = s2_valid_q;
  assign io.out_sign     = s2_sign_q;
  assign io.out_zero     = s2_zero_q;
  assign io.out_inf      = s2_inf_q;
  assign io.out_scale    = s2_scale_q;
  assign io.out_fraction = s2_frac_q;
  assign io.out_abs      = s2_abs_q;
  assign io.out_tag      = s2_tag_q;
endmodule

// File: tb/tb_posit_extract_pipe.sv
// Bench for posit_extract_pipe: a 32/ES3 and a 16/ES1 instance share one stimulus stream,
// each with its own expected-result queue filled at acceptance and drained at output.
module tb_posit_extract_pipe;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       iv = 1'b0;
  logic       ordy = 1'b1;
  logic [31:0] idat = '0;
  logic [7:0]  itag = '0;

  always #5 clk = ~clk;

  posit_extract_pipe_if #(.NBITS(32), .ES(3), .TAG_W(8)) ia ();
  posit_extract_pipe_if #(.NBITS(16), .ES(1), .TAG_W(8)) ib ();

  assign ia.in_valid  = iv;
  assign ia.in_data   = idat;
  assign ia.in_tag    = itag;
  assign ia.out_ready = ordy;
  assign ib.in_valid  = iv;
  assign ib.in_data   = idat[15:0];
  assign ib.in_tag    = itag;
  assign ib.out_ready = ordy;

  posit_extract_pipe #(.NBITS(32), .ES(3), .TAG_W(8)) dut_a (.clk(clk), .reset_n(reset_n), .io(ia));
  posit_extract_pipe #(.NBITS(16), .ES(1), .TAG_W(8)) dut_b (.clk(clk), .reset_n(reset_n), .io(ib));

  typedef struct {
    logic        sign;
    logic        zero;
    logic        inf;
    int          scale;
    logic [63:0] frac;
    logic [63:0] abs;
    logic [7:0]  tag;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t xa, xb;
  int n_vec = 0;
  int n_err = 0;
  int n_out_a = 0;
  int n_out_b = 0;

  // Bit-serial reference decoder: walk the magnitude from its MSB, consuming regime, terminator, exponent.
  function automatic exp_t model(input logic [63:0] x_in, input int nb, input int es, input logic [7:0] tag);
    exp_t r;
    logic [63:0] msk, x, u;
    logic rb;
    int pos, run, k, e, fb, nrem;
    msk = (64'd1 << nb) - 64'd1;
    x = x_in & msk;
    r.tag   = tag;
    r.sign  = x[nb-1];
    r.zero  = (x == 64'd0);
    r.inf   = (x == (64'd1 << (nb - 1)));
    u       = r.sign ? ((~x + 64'd1) & msk) : x;
    r.abs   = 64'd0;
    r.scale = 0;
    r.frac  = 64'd0;
    if (!r.zero && !r.inf) begin
      r.abs = u & (msk >> 1);
      pos = nb - 2;
      rb  = u[pos];
      run = 0;
      while (pos >= 0 && u[pos] == rb) begin
        run++;
        pos--;
      end
      k = rb ? run - 1 : -run;
      pos--;
      e = 0;
      for (int i = 0; i < es; i++) begin
        e = e * 2 + ((pos >= 0) ? int'(u[pos]) : 0);
        pos--;
      end
      r.scale = k * (1 << es) + e;
      fb   = nb - es - 3;
      nrem = (pos >= 0) ? pos + 1 : 0;
      r.frac = (u & ((64'd1 << nrem) - 64'd1)) << (fb - nrem);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (reset_n && ordy && ia.out_valid) begin
      n_vec++;
      n_out_a++;
      if (qa.size() == 0) begin
        n_err++;
        $display("FAIL sb_a_extra: got tag=%h with no item expected", ia.out_tag);
      end else begin
        xa = qa.pop_front();
        if (ia.out_sign !== xa.sign || ia.out_zero !== xa.zero || ia.out_inf !== xa.inf ||
            int'($signed(ia.out_scale)) !== xa.scale || 64'(ia.out_fraction) !== xa.frac ||
            64'(ia.out_abs) !== xa.abs || ia.out_tag !== xa.tag) begin
          n_err++;
          $display("FAIL sb_a_item: got s%b z%b i%b scale=%0d frac=%h abs=%h tag=%h, want s%b z%b i%b scale=%0d frac=%h abs=%h tag=%h",
                   ia.out_sign, ia.out_zero, ia.out_inf, $signed(ia.out_scale), ia.out_fraction, ia.out_abs, ia.out_tag,
                   xa.sign, xa.zero, xa.inf, xa.scale, xa.frac, xa.abs, xa.tag);
        end
      end
    end
    if (reset_n && ordy && ib.out_valid) begin
      n_vec++;
      n_out_b++;
      if (qb.size() == 0) begin
        n_err++;
        $display("FAIL sb_b_extra: got tag=%h with no item expected", ib.out_tag);
      end else begin
        xb = qb.pop_front();
        if (ib.out_sign !== xb.sign || ib.out_zero !== xb.zero || ib.out_inf !== xb.inf ||
            int'($signed(ib.out_scale)) !== xb.scale || 64'(ib.out_fraction) !== xb.frac ||
            64'(ib.out_abs) !== xb.abs || ib.out_tag !== xb.tag) begin
          n_err++;
          $display("FAIL sb_b_item: got s%b z%b i%b scale=%0d frac=%h abs=%h tag=%h, want s%b z%b i%b scale=%0d frac=%h abs=%h tag=%h",
                   ib.out_sign, ib.out_zero, ib.out_inf, $signed(ib.out_scale), ib.out_fraction, ib.out_abs, ib.out_tag,
                   xb.sign, xb.zero, xb.inf, xb.scale, xb.frac, xb.abs, xb.tag);
        end
      end
    end
  end

  task automatic test_reset;
    iv = 1'b0; ordy = 1'b1; idat = '0; itag = '0; reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_hs: out_valid=%b in_ready=%b, want 0 1", ia.out_valid, ia.in_ready);
    end
    @(negedge clk) reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_hs: out_valid=%b in_ready=%b, want 0 1", ia.out_valid, ia.in_ready);
    end
    n_vec++;
    if (ia.out_scale !== '0 || ia.out_fraction !== '0 || ia.out_abs !== '0 || ia.out_tag !== '0 ||
        ia.out_sign !== 1'b0 || ia.out_zero !== 1'b0 || ia.out_inf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_fields_a: scale=%h frac=%h abs=%h tag=%h s%b z%b i%b, want all 0",
               ia.out_scale, ia.out_fraction, ia.out_abs, ia.out_tag, ia.out_sign, ia.out_zero, ia.out_inf);
    end
    n_vec++;
    if (ib.out_valid !== 1'b0 || ib.out_scale !== '0 || ib.out_fraction !== '0 || ib.out_abs !== '0 || ib.out_tag !== '0) begin
      n_err++;
      $display("FAIL reset_fields_b: valid=%b scale=%h frac=%h abs=%h tag=%h, want all 0",
               ib.out_valid, ib.out_scale, ib.out_fraction, ib.out_abs, ib.out_tag);
    end
  endtask

  task automatic test_directed;
    logic [31:0] d_v [9] = '{32'h40000000, 32'h48000000, 32'h40200000, 32'hC0000000, 32'h7FFFFFFF,
                             32'h00000001, 32'h00000000, 32'h80000000, 32'hB8000000};
    int          s_v [9] = '{0, 2, 0, 0, 240, -240, 0, 0, 2};
    logic [63:0] f_v [9] = '{64'h0, 64'h0, 64'h200000, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
    logic [63:0] a_v [9] = '{64'h40000000, 64'h48000000, 64'h40200000, 64'h40000000, 64'h7FFFFFFF,
                             64'h1, 64'h0, 64'h0, 64'h48000000};
    logic [2:0]  szi [9] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b010, 3'b101, 3'b100};
    exp_t x;
    ordy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      x.sign  = szi[i][2];
      x.zero  = szi[i][1];
      x.inf   = szi[i][0];
      x.scale = s_v[i];
      x.frac  = f_v[i];
      x.abs   = a_v[i];
      x.tag   = 8'h11 + 8'(i);
      qa.push_back(x);
      qb.push_back(model({32'h0, d_v[i]}, 16, 1, x.tag));
      iv = 1'b1; idat = d_v[i]; itag = x.tag;
      if (i == 0) begin
        n_vec++;
        if (ia.in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL idle_in_ready: in_ready=%b, want 1", ia.in_ready);
        end
      end
      @(posedge clk);
      #1;
      iv = 1'b0;
      if (i == 0) begin
        n_vec++;
        if (ia.out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL latency_early: out_valid=%b one edge after accept, want 0", ia.out_valid);
        end
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (ia.out_valid !== 1'b1 || ia.out_tag !== x.tag) begin
        n_err++;
        $display("FAIL latency_2: out_valid=%b tag=%h, want 1 %h", ia.out_valid, ia.out_tag, x.tag);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure;
    logic [31:0]  d [5];
    logic [127:0] snap, cur;
    int  sent = 0;
    int  out0 = n_out_a;
    bit  snap_ok = 1'b0;
    bit  ir_checked = 1'b0;
    bit  fire;
    for (int i = 0; i < 5; i++) d[i] = $urandom;
    for (int cyc = 0; cyc < 40 && (sent < 5 || qa.size() > 0); cyc++) begin
      ordy = (cyc >= 4);
      iv = (sent < 5);
      if (sent < 5) begin
        idat = d[sent];
        itag = 8'hB0 + 8'(sent);
      end
      @(negedge clk);
      fire = iv && ia.in_ready;
      if (fire) begin
        qa.push_back(model({32'h0, idat}, 32, 3, itag));
        qb.push_back(model({32'h0, idat}, 16, 1, itag));
      end
      cur = 128'({ia.out_tag, ia.out_scale, ia.out_fraction, ia.out_abs, ia.out_sign, ia.out_zero, ia.out_inf});
      if (!ordy && ia.out_valid) begin
        if (!snap_ok) begin
          snap = cur;
          snap_ok = 1'b1;
        end else begin
          n_vec++;
          if (cur !== snap) begin
            n_err++;
            $display("FAIL stall_hold: outputs %h changed while stalled, want %h", cur, snap);
          end
        end
      end
      if (!ordy && sent == 2 && !ir_checked) begin
        ir_checked = 1'b1;
        n_vec++;
        if (ia.in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL full_in_ready: in_ready=%b with both stages full, want 0", ia.in_ready);
        end
      end
      @(posedge clk);
      #1;
      if (fire) sent++;
    end
    iv = 1'b0; ordy = 1'b1;
    n_vec++;
    if (n_out_a - out0 != 5 || qa.size() != 0 || !ir_checked || !snap_ok) begin
      n_err++;
      $display("FAIL bp_count: outputs=%0d pending=%0d full_seen=%0d stall_seen=%0d, want 5 0 1 1",
               n_out_a - out0, qa.size(), ir_checked, snap_ok);
    end
  endtask

  task automatic test_random;
    int acc = 0;
    int cyc = 0;
    bit fire;
    iv = 1'b0;
    while (acc < 10000 && cyc < 60000) begin
      ordy = ($urandom_range(0, 3) != 0);
      if (!iv && $urandom_range(0, 3) != 0) begin
        iv = 1'b1;
        itag = 8'($urandom);
        case ($urandom_range(0, 9))
          0:       idat = 32'h0;
          1:       idat = 32'h80000000;
          2:       idat = 32'h00008000;
          3:       idat = 32'hFFFFFFFF >> $urandom_range(0, 31);
          4:       idat = 32'h1 << $urandom_range(0, 31);
          default: idat = $urandom;
        endcase
      end
      @(negedge clk);
      fire = iv && ia.in_ready;
      if (fire) begin
        qa.push_back(model({32'h0, idat}, 32, 3, itag));
        qb.push_back(model({32'h0, idat}, 16, 1, itag));
      end
      @(posedge clk);
      #1;
      cyc++;
      if (fire) begin
        acc++;
        iv = 1'b0;
      end
    end
    iv = 1'b0; ordy = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (acc != 10000) begin
      n_err++;
      $display("FAIL rand_timeout: accepted=%0d, want 10000", acc);
    end
    n_vec++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_err++;
      $display("FAIL rand_drain: pending a=%0d b=%0d, want 0 0", qa.size(), qb.size());
    end
  endtask

  task automatic test_reset_midflight;
    int out0;
    ordy = 1'b0;
    iv = 1'b1; idat = 32'h48000000; itag = 8'hA0;
    @(posedge clk);
    #1;
    idat = 32'h40200000; itag = 8'hA1;
    @(posedge clk);
    #1;
    iv = 1'b0;
    n_vec++;
    if (ia.out_valid !== 1'b1 || ia.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL inflight_setup: out_valid=%b in_ready=%b, want 1 0", ia.out_valid, ia.in_ready);
    end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1 || ib.out_valid !== 1'b0 || ib.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_immediate: a v=%b r=%b b v=%b r=%b, want 0 1 0 1",
               ia.out_valid, ia.in_ready, ib.out_valid, ib.in_ready);
    end
    qa.delete();
    qb.delete();
    ordy = 1'b1;
    @(negedge clk) reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (ia.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stale_after_reset: out_valid=%b, want 0", ia.out_valid);
    end
    out0 = n_out_a;
    iv = 1'b1; idat = 32'hC0000000; itag = 8'hC5;
    qa.push_back(model({32'h0, idat}, 32, 3, itag));
    qb.push_back(model({32'h0, idat}, 16, 1, itag));
    @(posedge clk);
    #1;
    iv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (n_out_a - out0 != 1 || qa.size() != 0) begin
      n_err++;
      $display("FAIL post_reset_item: outputs=%0d pending=%0d, want 1 0", n_out_a - out0, qa.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_midflight();
    n_vec++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_err++;
      $display("FAIL final_drain: pending a=%0d b=%0d, want 0 0", qa.size(), qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
